// File: rtl/apb3_reg_target.sv
// apb3_reg_target: APB3 completer terminating one target port in a bank of
// read/write control registers, with configurable wait states and an error
// response for out-of-range or unaligned addresses.
//
// Ports:
//   PCLK, PRESET              clock, synchronous active-high reset
//   PSEL, PENABLE, PWRITE     APB control
//   PADDR, PWDATA             APB byte address and write data
//   PREADY, PRDATA, PSLVERR   APB response (combinational)
//   REG_OUT                   flattened register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   WR_STROBE                 one-cycle pulse per register written
module apb3_reg_target #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  output logic                           PREADY,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_OUT,
  output logic [NUM_REGS-1:0]            WR_STROBE
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W = 4;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_strobe_q, wr_strobe_d;

  logic [IDX_W-1:0] idx;
  logic             acc_err;
  logic             pready_c;

  // Decode of the address captured in the setup cycle.
  always_comb begin
    idx     = addr_q[IDX_W+1:2];
    acc_err = ((addr_q >> (IDX_W + 2)) != '0) || (addr_q[1:0] != 2'b00);
  end

  // Response is combinational from state, counter, captured address and regs.
  always_comb begin
    pready_c = (state_q == S_ACCESS) && PSEL && PENABLE && (cnt_q == '0);
    PREADY   = pready_c;
    PSLVERR  = pready_c && acc_err;
    PRDATA   = (pready_c && !acc_err && !write_q) ? regs_q[idx] : '0;
  end

  // Next-state, capture and register-update logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    regs_d      = regs_q;
    wr_strobe_d = '0;
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_W'(WAIT_STATES);
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
        end
      end
      S_ACCESS: begin
        if (!PSEL) begin
          // Abort: deselected mid-transfer, nothing is performed.
          state_d = S_IDLE;
        end else if (!PENABLE) begin
          // A fresh setup phase restarts the transfer.
          cnt_d   = CNT_W'(WAIT_STATES);
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_IDLE;
          if (write_q && !acc_err) begin
            regs_d[idx]      = wdata_q;
            wr_strobe_d[idx] = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      wr_strobe_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      wr_strobe_q <= wr_strobe_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Flatten the register bank for downstream logic.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign REG_OUT[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign WR_STROBE = wr_strobe_q;

endmodule

// File: tb/tb_apb3_reg_target.sv
// tb_apb3_reg_target: three instances (WAIT_STATES 1, 0, 3) driven by
// transaction tasks; a register-array model predicts every output each cycle.
module tb_apb3_reg_target;

  localparam int NI = 3;
  localparam int NR = 8;

  logic clk;
  logic preset;
  logic        psel   [NI];
  logic        pen    [NI];
  logic        pwr    [NI];
  logic [31:0] paddr  [NI];
  logic [31:0] pwdata [NI];
  logic        pready [NI];
  logic [31:0] prdata [NI];
  logic        pslverr[NI];
  logic [255:0] reg_out[NI];
  logic [7:0]  strobe [NI];

  // Model state
  logic [31:0] mreg [NI][NR];
  logic        exp_pready [NI];
  logic        exp_slverr [NI];
  logic [31:0] exp_prdata [NI];
  logic        chk_rd     [NI];
  logic [7:0]  exp_strobe [NI];
  logic        pend_wr    [NI];
  int          pend_idx   [NI];
  logic [31:0] pend_data  [NI];
  logic        chk_en;

  int checks;
  int failures;

  apb3_reg_target #(.WAIT_STATES(1)) u0 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(pen[0]), .PWRITE(pwr[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PREADY(pready[0]), .PRDATA(prdata[0]),
    .PSLVERR(pslverr[0]), .REG_OUT(reg_out[0]), .WR_STROBE(strobe[0]));
  apb3_reg_target #(.WAIT_STATES(0)) u1 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(pen[1]), .PWRITE(pwr[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PREADY(pready[1]), .PRDATA(prdata[1]),
    .PSLVERR(pslverr[1]), .REG_OUT(reg_out[1]), .WR_STROBE(strobe[1]));
  apb3_reg_target #(.WAIT_STATES(3)) u2 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(pen[2]), .PWRITE(pwr[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PREADY(pready[2]), .PRDATA(prdata[2]),
    .PSLVERR(pslverr[2]), .REG_OUT(reg_out[2]), .WR_STROBE(strobe[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(input int inst);
    case (inst)
      0: return 1;
      1: return 0;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input int inst, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%0h required=%0h", name, inst, act, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        logic [255:0] e;
        e = '0;
        for (int r = 0; r < NR; r++) e[r*32 +: 32] = mreg[i][r];
        check("pready", i, 256'(pready[i]), 256'(exp_pready[i]));
        if (exp_pready[i]) check("pslverr", i, 256'(pslverr[i]), 256'(exp_slverr[i]));
        if (chk_rd[i]) check("prdata", i, 256'(prdata[i]), 256'(exp_prdata[i]));
        check("wr_strobe", i, 256'(strobe[i]), 256'(exp_strobe[i]));
        check("reg_out", i, reg_out[i], e);
      end
    end
  end

  // Advance one cycle: apply the reset or the pending write seen at this edge,
  // then default all buses to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      exp_strobe[i] = '0;
      if (preset) begin
        for (int r = 0; r < NR; r++) mreg[i][r] = '0;
        pend_wr[i] = 1'b0;
      end else if (pend_wr[i]) begin
        mreg[i][pend_idx[i]] = pend_data[i];
        exp_strobe[i][pend_idx[i]] = 1'b1;
        pend_wr[i] = 1'b0;
      end
      exp_pready[i] = 1'b0;
      exp_slverr[i] = 1'b0;
      exp_prdata[i] = '0;
      chk_rd[i]     = 1'b1;
      psel[i]       = 1'b0;
      pen[i]        = 1'b0;
      pwr[i]        = 1'($urandom);
      paddr[i]      = $urandom;
      pwdata[i]     = $urandom;
    end
    preset = 1'b0;
  endtask

  // One transfer; abort_at >= 0 drops PSEL in that access cycle.
  task automatic xfer(input int inst, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input int abort_at);
    int   ws;
    logic err;
    int   idx;
    ws  = ws_of(inst);
    err = (addr >= 32'(4 * NR)) || (addr[1:0] != 2'b00);
    idx = int'(addr[4:2]);
    tick();
    psel[inst] = 1'b1; pen[inst] = 1'b0; pwr[inst] = wr;
    paddr[inst] = addr; pwdata[inst] = data;
    for (int k = 0; k <= ws; k++) begin
      tick();
      if (k == abort_at) return;
      // Bus fields wander during access; only the setup values may matter.
      psel[inst] = 1'b1; pen[inst] = 1'b1;
      if (k == ws) begin
        exp_pready[inst] = 1'b1;
        exp_slverr[inst] = err;
        if (!wr) exp_prdata[inst] = err ? 32'h0 : mreg[inst][idx];
        else if (err) exp_prdata[inst] = 32'h0;
        else chk_rd[inst] = 1'b0;
        if (wr && !err) begin
          pend_wr[inst] = 1'b1; pend_idx[inst] = idx; pend_data[inst] = data;
        end
      end
    end
  endtask

  task automatic junk_setup(input int inst);
    tick();
    psel[inst] = 1'b1; pen[inst] = 1'b0;
  endtask

  task automatic bad_enable(input int inst);
    tick();
    psel[inst] = 1'b1; pen[inst] = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0; chk_en = 1'b0;
    preset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      psel[i] = 1'b0; pen[i] = 1'b0; pwr[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
      pend_wr[i] = 1'b0; pend_idx[i] = 0; pend_data[i] = '0;
      exp_pready[i] = 1'b0; exp_slverr[i] = 1'b0; exp_prdata[i] = '0;
      chk_rd[i] = 1'b1; exp_strobe[i] = '0;
      for (int r = 0; r < NR; r++) mreg[i][r] = '0;
    end
    tick();
    chk_en = 1'b1;
    check("rst_regout_lit", 0, reg_out[0], 256'h0);

    // Write then read back register 2 (WAIT_STATES=1).
    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, -1);
    tick();
    check("wr08_strobe_lit", 0, 256'(strobe[0]), 256'h04);
    check("wr08_reg_lit", 0, 256'(reg_out[0][95:64]), 256'hDEADBEEF);
    check("wr08_model_lit", 0, 256'(mreg[0][2]), 256'hDEADBEEF);
    tick();
    check("wr08_strobe_gone_lit", 0, 256'(strobe[0]), 256'h0);
    xfer(0, 1'b0, 32'h08, 32'h0, -1);
    #1;
    check("rd08_lit", 0, 256'(prdata[0]), 256'hDEADBEEF);
    check("rd08_err_lit", 0, 256'(pslverr[0]), 256'h0);
    xfer(0, 1'b0, 32'h0C, 32'h0, -1);
    #1;
    check("rd0c_lit", 0, 256'(prdata[0]), 256'h0);

    // Error transfers.
    xfer(0, 1'b1, 32'h20, 32'h12345678, -1);
    #1;
    check("oor_err_lit", 0, 256'(pslverr[0]), 256'h1);
    xfer(0, 1'b1, 32'h05, 32'h12345678, -1);
    #1;
    check("unal_err_lit", 0, 256'(pslverr[0]), 256'h1);
    tick();
    check("err_regs_lit", 0, reg_out[0], {160'h0, 32'hDEADBEEF, 64'h0});

    // Back-to-back on WAIT_STATES=0.
    xfer(1, 1'b1, 32'h00, 32'h1, -1);
    xfer(1, 1'b1, 32'h04, 32'h2, -1);
    tick();
    check("b2b_reg_lit", 1, 256'(reg_out[1][63:0]), 256'h0000000200000001);

    // Abort on WAIT_STATES=3, then a valid read.
    xfer(2, 1'b1, 32'h10, 32'h55, 0);
    xfer(2, 1'b0, 32'h10, 32'h0, -1);
    #1;
    check("abort_rd_lit", 2, 256'(prdata[2]), 256'h0);

    // Reset in the first access cycle of a write to 0x00.
    tick();
    psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1; paddr[0] = 32'h0; pwdata[0] = 32'hA5A5A5A5;
    tick();
    psel[0] = 1'b1; pen[0] = 1'b1; preset = 1'b1;
    bad_enable(0);
    check("rst_mid_reg_lit", 0, reg_out[0], 256'h0);
    xfer(0, 1'b1, 32'h00, 32'h77, -1);
    tick();
    check("post_rst_wr_lit", 0, 256'(reg_out[0][31:0]), 256'h77);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int inst;
      int sel;
      logic [31:0] a;
      inst = int'($urandom_range(0, NI - 1));
      sel  = int'($urandom_range(0, 9));
      if (sel < 7) a = {27'h0, 3'($urandom), 2'b00};
      else if (sel < 9) a = {27'h0, 5'($urandom)};
      else a = $urandom;
      case ($urandom_range(0, 7))
        0: begin
          for (int g = 0; g < int'($urandom_range(1, 2)); g++) tick();
          bad_enable(inst);
        end
        1: junk_setup(inst);
        2: tick();
        default: ;
      endcase
      xfer(inst, 1'($urandom), a, $urandom,
           ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, ws_of(inst))) : -1);
      if ($urandom_range(0, 49) == 0) begin
        tick();
        preset = 1'b1;
      end
    end
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb3_reg_target.md
# apb3_reg_target

APB3 completer that terminates one APB3 target port (such as the output of the team's APB3 initiator mux) in a bank of read/write control registers. It supports a configurable number of wait states and flags errors for out-of-range or unaligned addresses. It exposes the register contents and per-register write strobes to downstream sound-generation logic.

## Interface
- ADDR_WIDTH, 32: width of PADDR.
- DATA_WIDTH, 32: register and data-bus width.
- NUM_REGS, 8: number of registers, a power of two from 2 to 64, word-spaced at byte offsets 0, 4, 8, ...
- WAIT_STATES, 1: extra access-phase cycles before PREADY asserts, 0..15.

Ports:
- PCLK  in  1  single clock; all logic is on the rising edge.
- PRESET  in  1  synchronous reset, active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PREADY  out  1  transfer-complete indicator.
- PRDATA  out  DATA_WIDTH  read data; 0 whenever PREADY=0.
- PSLVERR  out  1  error response; meaningful only while PREADY=1.
- REG_OUT  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- WR_STROBE  out  NUM_REGS  one-cycle pulse for each register written.

## Operation
- FSM states:
  - IDLE: PSEL=1 and PENABLE=0 is a setup phase. Capture PADDR, PWRITE and PWDATA, load the wait counter with WAIT_STATES, and go to ACCESS. Any other input combination stays in IDLE.
  - ACCESS: while PENABLE=1 and the counter is nonzero, decrement the counter.
- Transfer completion:
  - PREADY = (state==ACCESS) && PSEL && PENABLE && (counter==0). This is combinational from the state, the counter and the inputs.
  - On the completing edge, perform the access and return to IDLE.
- Address decode:
  - idx = PADDR[log2(NUM_REGS)+1:2].
  - The address is in range when the PADDR bits above log2(NUM_REGS)+1 are all zero.
  - The address is aligned when PADDR[1:0]==0.
- Valid write: on the completing edge, reg[idx] <= PWDATA and WR_STROBE[idx] <= 1. The strobe is registered and lasts exactly one cycle.
- Valid read: PRDATA = reg[idx] while PREADY=1, with PSLVERR=0.
- Error (out of range or unaligned):
  - PSLVERR=1 while PREADY=1 and PRDATA=0.
  - No register changes and no strobe fires.
  - The error transfer still takes the full wait-state count.
- Abort: if PSEL drops while in ACCESS, go to IDLE. No write, no strobe, no PREADY.
- Protocol violations:
  - PENABLE=1 in IDLE without a preceding setup phase is ignored and PREADY stays 0.
  - PSEL=1 with PENABLE=0 while in ACCESS restarts: it is treated as a new setup phase.
- Capture rule: address, direction and write data are taken from the setup cycle. Changes to these inputs during ACCESS are ignored.

## Timing
- Reset values (PRESET=1 at any edge): state IDLE, counter 0, all registers 0, REG_OUT 0, WR_STROBE 0, PREADY 0, PRDATA 0, PSLVERR 0.
- Reset mid-transfer aborts the transfer with no register update.
- Transfer length: 1 setup cycle plus WAIT_STATES+1 access cycles. With WAIT_STATES=0, PREADY is high in the first access cycle.
- Write visibility:
  - REG_OUT shows the new value in the cycle after the completing edge.
  - WR_STROBE is high in that same cycle only.
- Back-to-back transfers: a setup phase in the cycle immediately after completion is accepted with no idle gap, so the bus carries one transfer per WAIT_STATES+2 cycles.
- Read-after-write to the same register in consecutive transfers returns the new value.
- PRDATA and PSLVERR are combinational from the stored registers and the captured address. They are not registered.

## Test plan
- Reset, then write 0xDEADBEEF to 0x08 with WAIT_STATES=1 -> PREADY low in the first access cycle and high in the second. REG_OUT[2] = 0xDEADBEEF and WR_STROBE = 8'b0000_0100 for exactly one cycle after completion.
- Read 0x08 -> PRDATA = 0xDEADBEEF and PSLVERR=0 on the PREADY cycle. Read 0x0C -> PRDATA 0.
- Write to 0x20 (out of range for NUM_REGS=8) and to 0x05 (unaligned) -> PSLVERR=1 with PREADY, PRDATA 0, no WR_STROBE, all registers unchanged.
- Back-to-back writes of 0x1 to 0x00 and 0x2 to 0x04 with WAIT_STATES=0 -> each completes in 2 cycles, strobes on bits 0 and 1 in successive transfers, final REG_OUT[0]=1 and REG_OUT[1]=2.
- Abort: drop PSEL in the first access cycle of a write with WAIT_STATES=3 -> no PREADY, no strobe, register unchanged. A following valid read succeeds.
- Assert PRESET during the access phase of a write to 0x00 -> all outputs 0 on the next cycle, REG_OUT[0] stays 0, and a subsequent transfer completes normally.
